// File: rtl/id_ex_shift_operand_stage.sv
// ID/EX pipeline register for the ALU/barrel-shifter path.
// Resolves operand forwarding (EX > MEM > WB > regfile) and load-use hazards.
module id_ex_shift_operand_stage #(
    parameter int         DATA_W  = 32,
    parameter int         REG_AW  = 5,
    parameter logic [3:0] ALU_SLL = 4'd5,
    parameter logic [3:0] ALU_SRL = 4'd6,
    parameter logic [3:0] ALU_SRA = 4'd7
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [3:0]        id_alu_op,
    input  logic [REG_AW-1:0] id_ra_addr,
    input  logic [DATA_W-1:0] id_ra_data,
    input  logic [REG_AW-1:0] id_rb_addr,
    input  logic [DATA_W-1:0] id_rb_data,
    input  logic              id_use_imm,
    input  logic [DATA_W-1:0] id_imm,
    input  logic [REG_AW-1:0] id_rd,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              stall,
    input  logic              flush,
    input  logic [DATA_W-1:0] ex_result,
    input  logic              mem_wen,
    input  logic [REG_AW-1:0] mem_rd,
    input  logic [DATA_W-1:0] mem_data,
    input  logic              wb_wen,
    input  logic [REG_AW-1:0] wb_rd,
    input  logic [DATA_W-1:0] wb_data,
    output logic              ex_valid,
    output logic [3:0]        ex_alu_op,
    output logic [DATA_W-1:0] ex_a,
    output logic [DATA_W-1:0] ex_b,
    output logic [REG_AW-1:0] ex_rd,
    output logic              ex_reg_write,
    output logic              ex_mem_read,
    output logic              hazard_stall
);

    logic              ex_valid_q,     ex_valid_d;
    logic [3:0]        ex_alu_op_q,    ex_alu_op_d;
    logic [DATA_W-1:0] ex_a_q,         ex_a_d;
    logic [DATA_W-1:0] ex_b_q,         ex_b_d;
    logic [REG_AW-1:0] ex_rd_q,        ex_rd_d;
    logic              ex_reg_write_q, ex_reg_write_d;
    logic              ex_mem_read_q,  ex_mem_read_d;

    logic              ex_fwd_ok;
    logic              is_shift;
    logic              ra_match;
    logic              rb_match;
    logic [DATA_W-1:0] fwd_a;
    logic [DATA_W-1:0] fwd_b;
    logic [DATA_W-1:0] b_sel;

    // A load in EX has no data yet, so it is never a forwarding source.
    assign ex_fwd_ok = ex_valid_q & ex_reg_write_q & ~ex_mem_read_q;
    assign is_shift  = (id_alu_op == ALU_SLL) | (id_alu_op == ALU_SRL) | (id_alu_op == ALU_SRA);
    assign ra_match  = (id_ra_addr == ex_rd_q);
    assign rb_match  = (id_rb_addr == ex_rd_q);

    assign hazard_stall = id_valid & ex_valid_q & ex_mem_read_q & (ex_rd_q != '0)
                        & (ra_match | (rb_match & ~id_use_imm));

    always_comb begin
        fwd_a = id_ra_data;
        if (id_ra_addr == '0)
            fwd_a = '0;
        else if (ex_fwd_ok && (ex_rd_q == id_ra_addr))
            fwd_a = ex_result;
        else if (mem_wen && (mem_rd == id_ra_addr))
            fwd_a = mem_data;
        else if (wb_wen && (wb_rd == id_ra_addr))
            fwd_a = wb_data;

        fwd_b = id_rb_data;
        if (id_rb_addr == '0)
            fwd_b = '0;
        else if (ex_fwd_ok && (ex_rd_q == id_rb_addr))
            fwd_b = ex_result;
        else if (mem_wen && (mem_rd == id_rb_addr))
            fwd_b = mem_data;
        else if (wb_wen && (wb_rd == id_rb_addr))
            fwd_b = wb_data;

        // Immediate shifts carry only the 5-bit shamt; register B is passed unmasked.
        if (id_use_imm)
            b_sel = is_shift ? {{(DATA_W-5){1'b0}}, id_imm[4:0]} : id_imm;
        else
            b_sel = fwd_b;
    end

    always_comb begin
        ex_valid_d     = ex_valid_q;
        ex_alu_op_d    = ex_alu_op_q;
        ex_a_d         = ex_a_q;
        ex_b_d         = ex_b_q;
        ex_rd_d        = ex_rd_q;
        ex_reg_write_d = ex_reg_write_q;
        ex_mem_read_d  = ex_mem_read_q;

        if (flush || (!stall && (hazard_stall || !id_valid))) begin
            ex_valid_d     = 1'b0;
            ex_alu_op_d    = '0;
            ex_a_d         = '0;
            ex_b_d         = '0;
            ex_rd_d        = '0;
            ex_reg_write_d = 1'b0;
            ex_mem_read_d  = 1'b0;
        end else if (!stall) begin
            ex_valid_d     = 1'b1;
            ex_alu_op_d    = id_alu_op;
            ex_a_d         = fwd_a;
            ex_b_d         = b_sel;
            ex_rd_d        = id_rd;
            ex_reg_write_d = id_reg_write;
            ex_mem_read_d  = id_mem_read;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_valid_q     <= 1'b0;
            ex_alu_op_q    <= '0;
            ex_a_q         <= '0;
            ex_b_q         <= '0;
            ex_rd_q        <= '0;
            ex_reg_write_q <= 1'b0;
            ex_mem_read_q  <= 1'b0;
        end else begin
            ex_valid_q     <= ex_valid_d;
            ex_alu_op_q    <= ex_alu_op_d;
            ex_a_q         <= ex_a_d;
            ex_b_q         <= ex_b_d;
            ex_rd_q        <= ex_rd_d;
            ex_reg_write_q <= ex_reg_write_d;
            ex_mem_read_q  <= ex_mem_read_d;
        end
    end

    assign ex_valid     = ex_valid_q;
    assign ex_alu_op    = ex_alu_op_q;
    assign ex_a         = ex_a_q;
    assign ex_b         = ex_b_q;
    assign ex_rd        = ex_rd_q;
    assign ex_reg_write = ex_reg_write_q;
    assign ex_mem_read  = ex_mem_read_q;

endmodule
